// File: rtl/div32_ctrl_pkg.sv
// rtl/div32_ctrl_pkg.sv - shared FSM state type and constants for div32_ctrl
//
// Contents:
//   state_t        IDLE / RUN / FINISH controller states
//   DIV_ITER       number of restoring-division iterations (one quotient bit each)
//   DIV0_QUOTIENT  quotient reported for a divide by zero
package div32_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int          DIV_ITER      = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div32_ctrl_sub32.sv
// rtl/div32_ctrl_sub32.sv - combinational 32-bit trial subtractor
//
// Ports:
//   A  in  32  minuend (shifted partial remainder)
//   B  in  32  subtrahend (divisor)
//   R  out 32  A - B, modulo 2^32
module sub32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] R
);

  assign R = A - B;

endmodule

// File: rtl/div32_ctrl.sv
// rtl/div32_ctrl.sv - sequential restoring divider with start/busy/done handshake
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst_n        in   1      synchronous active-low reset
//   start        in   1      request pulse, sampled only while busy=0
//   dividend     in   WIDTH  numerator, captured on accepted start
//   divisor      in   WIDTH  denominator, captured on accepted start
//   is_signed    in   1      signed operation select (only with DIV32_SIGNED_EN)
//   busy         out  1      operation in progress (RUN or FINISH)
//   done         out  1      one-cycle pulse, results valid in the same cycle
//   quotient     out  WIDTH  registered quotient
//   remainder    out  WIDTH  registered remainder
//   div_by_zero  out  1      registered divide-by-zero flag
//
// Build option: define DIV32_SIGNED_EN to add the is_signed input.
module div32_ctrl
  import div32_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             accept;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             sgn_quot, sgn_rem;

  assign shifted = {prem_q, dvd_q[WIDTH-1]};
  assign accept  = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvs_q);

  sub32 u_sub32 (
    .A(shifted[WIDTH-1:0]),
    .B(dvs_q),
    .R(trial)
  );

  // Signed operands are reduced to magnitudes at capture; the result signs are
  // remembered and applied on the final RUN cycle so latency is unaffected.
`ifdef DIV32_SIGNED_EN
  always_comb begin
    dvd_mag  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    sgn_quot = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    sgn_rem  = is_signed && dividend[WIDTH-1];
  end
`else
  always_comb begin
    dvd_mag  = dividend;
    dvs_mag  = divisor;
    sgn_quot = 1'b0;
    sgn_rem  = 1'b0;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    prem_d     = prem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    busy       = (state_q != IDLE);
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          if (divisor == '0) begin
            quot_d  = DIV0_QUOTIENT;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = FINISH;
          end else begin
            dvd_d      = dvd_mag;
            dvs_d      = dvs_mag;
            prem_d     = '0;
            cnt_d      = '0;
            neg_quot_d = sgn_quot;
            neg_rem_d  = sgn_rem;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        // After DIV_ITER iterations one more RUN cycle publishes the
        // sign-corrected results into the output registers.
        if (cnt_q == 6'(DIV_ITER)) begin
          quot_d  = neg_quot_q ? -dvd_q : dvd_q;
          rem_d   = neg_rem_q ? -prem_q : prem_q;
          state_d = FINISH;
        end else begin
          prem_d = accept ? trial : shifted[WIDTH-1:0];
          dvd_d  = {dvd_q[WIDTH-2:0], accept};
          cnt_d  = cnt_q + 6'd1;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      prem_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      prem_q     <= prem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
